// File: rtl/add32_sequencer_if.sv
// Handshake and operand/result bundle for the byte-serial 32-bit adder/subtractor.
interface add32_sequencer_if;
  logic        start;
  logic        sub;
  logic [31:0] a;
  logic [31:0] b;
  logic        carry_in;
  logic        busy;
  logic        done;
  logic [31:0] sum;
  logic        carry_out;
  logic        overflow;

  modport master (
    output start, sub, a, b, carry_in,
    input  busy, done, sum, carry_out, overflow
  );

  modport slave (
    input  start, sub, a, b, carry_in,
    output busy, done, sum, carry_out, overflow
  );
endinterface

// File: rtl/add32_sequencer.sv
// 32-bit add/subtract computed one byte per cycle through a single shared 8-bit ripple adder.
// The 8-bit adder's "overflow" port carries its unsigned carry-out.
module adder_8bit (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       cin,
  output logic [7:0] sum,
  output logic       overflow
);
  logic [8:0] carry;

  assign carry[0] = cin;

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_bit
      assign sum[gi]      = a[gi] ^ b[gi] ^ carry[gi];
      assign carry[gi+1]  = (a[gi] & b[gi]) | (carry[gi] & (a[gi] ^ b[gi]));
    end
  endgenerate

  assign overflow = carry[8];
endmodule

module add32_sequencer (
  input  logic               clk,
  input  logic               n_rst,
  add32_sequencer_if.slave   bus
);
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_reg, state_next;
  logic [1:0]  idx_reg, idx_next;
  logic        c_reg, c_next;
  logic [31:0] a_reg, a_next;
  logic [31:0] b_reg, b_next;
  logic [31:0] sum_reg, sum_next;
  logic        carry_out_reg, carry_out_next;
  logic        overflow_reg, overflow_next;

  logic [7:0]  add_sum;
  logic        add_carry;

  adder_8bit u_adder (
    .a        (a_reg[{idx_reg, 3'b000} +: 8]),
    .b        (b_reg[{idx_reg, 3'b000} +: 8]),
    .cin      (c_reg),
    .sum      (add_sum),
    .overflow (add_carry)
  );

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_reg     <= IDLE;
      idx_reg       <= 2'd0;
      c_reg         <= 1'b0;
      a_reg         <= 32'd0;
      b_reg         <= 32'd0;
      sum_reg       <= 32'd0;
      carry_out_reg <= 1'b0;
      overflow_reg  <= 1'b0;
    end else begin
      state_reg     <= state_next;
      idx_reg       <= idx_next;
      c_reg         <= c_next;
      a_reg         <= a_next;
      b_reg         <= b_next;
      sum_reg       <= sum_next;
      carry_out_reg <= carry_out_next;
      overflow_reg  <= overflow_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    idx_next       = idx_reg;
    c_next         = c_reg;
    a_next         = a_reg;
    b_next         = b_reg;
    sum_next       = sum_reg;
    carry_out_next = carry_out_reg;
    overflow_next  = overflow_reg;

    case (state_reg)
      IDLE: begin
        if (bus.start) begin
          // Subtraction is a + ~b + 1, so the inversion happens once at capture.
          a_next     = bus.a;
          b_next     = bus.sub ? ~bus.b : bus.b;
          c_next     = bus.sub | bus.carry_in;
          sum_next   = 32'd0;
          idx_next   = 2'd0;
          state_next = CALC;
        end
      end
      CALC: begin
        sum_next[{idx_reg, 3'b000} +: 8] = add_sum;
        c_next   = add_carry;
        idx_next = idx_reg + 2'd1;
        if (idx_reg == 2'd3) begin
          state_next     = DONE;
          carry_out_next = add_carry;
          overflow_next  = (a_reg[31] == b_reg[31]) && (add_sum[7] != a_reg[31]);
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign bus.busy      = (state_reg != IDLE);
  assign bus.done      = (state_reg == DONE);
  assign bus.sum       = sum_reg;
  assign bus.carry_out = carry_out_reg;
  assign bus.overflow  = overflow_reg;
endmodule

// File: tb/tb_add32_sequencer.sv
// Directed bench for add32_sequencer: reset, add/sub vectors, busy protection and mid-operation reset.
module tb_add32_sequencer;
  logic clk;
  logic n_rst;
  int   checks;
  int   errors;

  add32_sequencer_if bus ();

  add32_sequencer dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    n_rst        = 1'b0;
    bus.start    = 1'b1;
    bus.sub      = 1'b0;
    bus.a        = 32'hDEADBEEF;
    bus.b        = 32'h12345678;
    bus.carry_in = 1'b1;
    tick();
    tick();
    checks++;
    if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", bus.busy); end
    checks++;
    if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", bus.done); end
    checks++;
    if (bus.sum !== 32'h0) begin errors++; $display("FAIL reset_sum got %h want 00000000", bus.sum); end
    checks++;
    if (bus.carry_out !== 1'b0 || bus.overflow !== 1'b0) begin
      errors++; $display("FAIL reset_flags got co=%b ov=%b want 0 0", bus.carry_out, bus.overflow);
    end
    bus.start = 1'b0;
    n_rst     = 1'b1;
    tick();
    checks++;
    if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_idle_busy got %b want 0", bus.busy); end
    $display("test_reset: done");
  endtask

  // Shared stimulus/check body for add and sub vector tables.
  task automatic run_vectors(input string tag, input int n,
                             input logic        vs   [6],
                             input logic [31:0] va   [6],
                             input logic [31:0] vb   [6],
                             input logic        vc   [6],
                             input logic [31:0] vsum [6],
                             input logic        vco  [6],
                             input logic        vov  [6]);
    for (int i = 0; i < n; i++) begin
      bus.sub = vs[i]; bus.a = va[i]; bus.b = vb[i]; bus.carry_in = vc[i];
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      checks++;
      if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin
        errors++; $display("FAIL %s[%0d]_accept got busy=%b done=%b want 1 0", tag, i, bus.busy, bus.done);
      end
      for (int k = 1; k <= 3; k++) begin
        tick();
        checks++;
        if (bus.done !== 1'b0) begin errors++; $display("FAIL %s[%0d]_early_done E%0d got %b want 0", tag, i, k, bus.done); end
      end
      tick();
      checks++;
      if (bus.done !== 1'b1) begin errors++; $display("FAIL %s[%0d]_done_E4 got %b want 1", tag, i, bus.done); end
      checks++;
      if (bus.sum !== vsum[i] || bus.carry_out !== vco[i] || bus.overflow !== vov[i]) begin
        errors++;
        $display("FAIL %s[%0d]_result got sum=%h co=%b ov=%b want sum=%h co=%b ov=%b",
                 tag, i, bus.sum, bus.carry_out, bus.overflow, vsum[i], vco[i], vov[i]);
      end
      tick();
      checks++;
      if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.sum !== vsum[i]) begin
        errors++;
        $display("FAIL %s[%0d]_hold got done=%b busy=%b sum=%h want 0 0 %h", tag, i, bus.done, bus.busy, bus.sum, vsum[i]);
      end
      $display("%s[%0d]: a=%h b=%h sub=%b cin=%b -> sum=%h co=%b ov=%b", tag, i, va[i], vb[i], vs[i], vc[i],
               bus.sum, bus.carry_out, bus.overflow);
    end
  endtask

  task automatic test_add();
    logic        vs[6]; logic [31:0] va[6]; logic [31:0] vb[6]; logic vc[6];
    logic [31:0] vsum[6]; logic vco[6]; logic vov[6];
    vs = '{0, 0, 0, 0, 0, 0};
    va   = '{32'h000000FF, 32'hFFFFFFFF, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 0};
    vb   = '{32'h00000001, 32'h00000000, 32'h00000001, 32'h00000002, 32'h80000000, 0};
    vc   = '{0, 1, 0, 1, 0, 0};
    vsum = '{32'h00000100, 32'h00000000, 32'h80000000, 32'h00000004, 32'h00000000, 0};
    vco  = '{0, 1, 0, 0, 1, 0};
    vov  = '{0, 0, 1, 0, 1, 0};
    run_vectors("add", 5, vs, va, vb, vc, vsum, vco, vov);
  endtask

  task automatic test_sub();
    logic        vs[6]; logic [31:0] va[6]; logic [31:0] vb[6]; logic vc[6];
    logic [31:0] vsum[6]; logic vco[6]; logic vov[6];
    vs   = '{1, 1, 1, 0, 0, 0};
    va   = '{32'h00000005, 32'h80000000, 32'h00000007, 0, 0, 0};
    vb   = '{32'h00000007, 32'h00000001, 32'h00000005, 0, 0, 0};
    // carry_in set high to show it is ignored in subtract mode
    vc   = '{1, 0, 1, 0, 0, 0};
    vsum = '{32'hFFFFFFFE, 32'h7FFFFFFF, 32'h00000002, 0, 0, 0};
    vco  = '{0, 1, 1, 0, 0, 0};
    vov  = '{0, 1, 0, 0, 0, 0};
    run_vectors("sub", 3, vs, va, vb, vc, vsum, vco, vov);
  endtask

  task automatic test_back_to_back();
    bus.sub = 1'b0; bus.a = 32'h11111111; bus.b = 32'h22222222; bus.carry_in = 1'b0;
    bus.start = 1'b1;
    tick();  // E0
    for (int k = 1; k <= 3; k++) begin
      bus.a = 32'hFFFF0000 + k; bus.b = 32'h0000FFFF * k; bus.sub = k[0]; bus.carry_in = 1'b1;
      tick();
      checks++;
      if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin
        errors++; $display("FAIL b2b_busy E%0d got busy=%b done=%b want 1 0", k, bus.busy, bus.done);
      end
    end
    bus.a = 32'hA5A5A5A5; bus.b = 32'h5A5A5A5A; bus.sub = 1'b1;
    tick();  // E4
    checks++;
    if (bus.done !== 1'b1 || bus.sum !== 32'h33333333 || bus.carry_out !== 1'b0 || bus.overflow !== 1'b0) begin
      errors++;
      $display("FAIL b2b_first got done=%b sum=%h co=%b ov=%b want 1 33333333 0 0",
               bus.done, bus.sum, bus.carry_out, bus.overflow);
    end
    $display("b2b first: sum=%h done=%b", bus.sum, bus.done);
    tick();  // E5: DONE -> IDLE, start not sampled
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      errors++; $display("FAIL b2b_E5 got busy=%b done=%b want 0 0", bus.busy, bus.done);
    end
    bus.a = 32'h00000010; bus.b = 32'h00000003; bus.sub = 1'b0; bus.carry_in = 1'b0;
    tick();  // second op accepted since start is still high
    checks++;
    if (bus.busy !== 1'b1) begin errors++; $display("FAIL b2b_second_accept got busy=%b want 1", bus.busy); end
    for (int k = 1; k <= 3; k++) begin
      bus.a = 32'hFFFFFFFF; bus.b = 32'hFFFFFFFF; bus.carry_in = 1'b1;
      tick();
      checks++;
      if (bus.done !== 1'b0) begin errors++; $display("FAIL b2b_second_early E%0d got %b want 0", k, bus.done); end
    end
    bus.start = 1'b0;
    tick();
    checks++;
    if (bus.done !== 1'b1 || bus.sum !== 32'h00000013) begin
      errors++; $display("FAIL b2b_second got done=%b sum=%h want 1 00000013", bus.done, bus.sum);
    end
    $display("b2b second: sum=%h done=%b", bus.sum, bus.done);
    tick();
  endtask

  task automatic test_reset_mid();
    bus.sub = 1'b0; bus.a = 32'h01020304; bus.b = 32'h01010101; bus.carry_in = 1'b0;
    bus.start = 1'b1;
    tick();  // E0
    bus.start = 1'b0;
    tick();  // E1: low byte written
    checks++;
    if (bus.sum !== 32'h00000005) begin errors++; $display("FAIL mid_partial got %h want 00000005", bus.sum); end
    n_rst = 1'b0;
    tick();  // E2 under reset
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.sum !== 32'h0 || bus.carry_out !== 1'b0 || bus.overflow !== 1'b0) begin
      errors++;
      $display("FAIL mid_abort got busy=%b done=%b sum=%h co=%b ov=%b want all 0",
               bus.busy, bus.done, bus.sum, bus.carry_out, bus.overflow);
    end
    n_rst = 1'b1;
    bus.a = 32'h12345678; bus.b = 32'h11111111; bus.start = 1'b1;
    tick();  // first edge out of reset accepts
    bus.start = 1'b0;
    checks++;
    if (bus.busy !== 1'b1) begin errors++; $display("FAIL mid_restart_accept got busy=%b want 1", bus.busy); end
    for (int k = 1; k <= 3; k++) begin
      tick();
      checks++;
      if (bus.done !== 1'b0) begin errors++; $display("FAIL mid_stray_done E%0d got %b want 0", k, bus.done); end
    end
    tick();
    checks++;
    if (bus.done !== 1'b1 || bus.sum !== 32'h23456789 || bus.carry_out !== 1'b0 || bus.overflow !== 1'b0) begin
      errors++;
      $display("FAIL mid_restart_result got done=%b sum=%h co=%b ov=%b want 1 23456789 0 0",
               bus.done, bus.sum, bus.carry_out, bus.overflow);
    end
    $display("reset_mid restart: sum=%h done=%b", bus.sum, bus.done);
    tick();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    n_rst = 1'b0;
    bus.start = 1'b0; bus.sub = 1'b0; bus.a = 32'd0; bus.b = 32'd0; bus.carry_in = 1'b0;
    test_reset();
    test_add();
    test_sub();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end
endmodule
